uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one byte-level UART transmitter among four requesters. It accepts one byte per grant over a valid/ready handshake and launches it on the transmitter with a one-cycle start strobe. It then tracks the transmitter's busy flag through the frame and enforces a configurable idle gap between frames. It sits between the message sources (status reporters, periodic senders) and the UART TX serializer.

Parameters:
GAP_CYCLES, 5208, idle clk cycles inserted after tx_busy falls before the next grant (0 = no gap); counter is 32 bits.
ACK_TIMEOUT, 16, max clk cycles after tx_start to wait for tx_busy to rise (must be >= 1); counter is 16 bits.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  4  per-requester byte-available flag, bit i = requester i
req_data  input  32  packed bytes, requester i at [8i+7:8i]
req_ready  output  4  one-hot, one-cycle pulse; byte of requester i consumed this cycle
tx_data  output  8  byte presented to the serializer, held stable from the start strobe until the next grant
tx_start  output  1  one-cycle launch strobe to the serializer
tx_busy  input  1  serializer frame-in-progress flag
grant_id  output  2  index of the most recently granted requester
sched_busy  output  1  high in every state except IDLE
timeout_err  output  1  one-cycle pulse when tx_busy fails to rise within ACK_TIMEOUT

Behaviour:
- Reset (async, rst_n low): state=IDLE; req_ready=0, tx_start=0, tx_data=0, grant_id=0, sched_busy=0, timeout_err=0; internal last-grant pointer=3, so requester 0 has first priority; gap and timeout counters=0.
- States: IDLE, START, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: if req_valid != 0, pick the first set bit searching upward from (last+1) mod 4 with wrap-around.
  - Same cycle: req_ready[k]=1 (combinational from state and req_valid), so the handshake completes on that edge.
  - On that edge: tx_data<=req_data[k], grant_id<=k, last<=k, state<=START.
  - If req_valid==0, stay in IDLE.
- START: tx_start=1 for exactly this cycle; clear timeout counter; go to WAIT_ACK.
- WAIT_ACK: on tx_busy=1 go to WAIT_DONE. Otherwise increment the counter. When the count reaches ACK_TIMEOUT-1 without busy, pulse timeout_err for one cycle and go to GAP; the byte is dropped and not retried.
- WAIT_DONE: stay while tx_busy=1. On tx_busy=0, go to GAP with the gap counter cleared; if GAP_CYCLES=0, go to IDLE instead.
- GAP: increment the gap counter. At GAP_CYCLES-1 go to IDLE. tx_busy is ignored in this state.
- Latency: grant edge to tx_start high is 1 cycle. Minimum cycles between successive grants = 2 + ack wait + busy duration + GAP_CYCLES + 1.
- req_ready is never asserted outside IDLE. At most one bit is ever high.
- Requester contract: req_valid/req_data must stay stable until req_ready. Deasserting req_valid before a grant withdraws the request without error.
- Simultaneous requests are served strictly in rotation; no requester waits more than 3 other grants.
- tx_busy already high in IDLE (foreign frame) does not block a grant. In WAIT_ACK it counts as the acknowledge immediately.
- Reset mid-frame: everything returns to reset values asynchronously. tx_start drops at once; no byte is re-sent after reset.
- sched_busy is registered from the state: 1 in START, WAIT_ACK, WAIT_DONE and GAP.

Test Plan:
1. Reset; requester 2 only (req_data[23:16]=8'h0F); serializer model raises tx_busy 1 cycle after tx_start for 10 cycles. Expect: req_ready=4'b0100 for one cycle, tx_start one cycle later, tx_data=8'h0F, grant_id=2, next grant no earlier than GAP_CYCLES cycles after tx_busy falls.
2. All four requesters valid continuously with bytes A0..A3, GAP_CYCLES=4. Expect grant order 0,1,2,3,0 and tx_data sequence A0,A1,A2,A3,A0.
3. After a grant to requester 1, only requesters 1 and 3 remain valid. Expect the next grant goes to 3, then 1.
4. Serializer never raises tx_busy, ACK_TIMEOUT=16. Expect timeout_err pulse exactly 16 cycles after tx_start, then GAP, then IDLE; the next requester is served.
5. Assert rst_n low while in WAIT_DONE. Expect tx_start=0, req_ready=0, sched_busy=0 immediately; after release, the first grant goes to requester 0 when all are valid.
6. GAP_CYCLES=0 with back-to-back requests. Expect a new grant the cycle after the edge on which tx_busy is sampled low.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Bundle between the requesters, the round-robin UART scheduler and the byte serializer.
// The scheduler connects through master; the requesters and serializer connect through slave.
interface uart_tx_sched_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        sched_busy;
  logic        timeout_err;

  modport master (
    input  req_valid,
    input  req_data,
    input  tx_busy,
    output req_ready,
    output tx_data,
    output tx_start,
    output grant_id,
    output sched_busy,
    output timeout_err
  );

  modport slave (
    output req_valid,
    output req_data,
    output tx_busy,
    input  req_ready,
    input  tx_data,
    input  tx_start,
    input  grant_id,
    input  sched_busy,
    input  timeout_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte UART transmitter among four requesters,
// with start strobe, busy-ack timeout and a configurable inter-frame idle gap.
module uart_tx_sched #(
  parameter int unsigned GAP_CYCLES  = 5208,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
  localparam bit          NO_GAP   = (GAP_CYCLES == 0);

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic        sched_busy_q, sched_busy_d;

  logic [3:0]  req_ready_c;
  logic        tx_start_c;
  logic        timeout_c;

  // Candidate gi is the requester (gi+1) places after the last grant.
  logic [1:0]  cand_idx [4];
  logic [3:0]  cand_hit;
  logic [1:0]  pick;
  logic        pick_vld;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = last_q + 2'(gi + 1);
      assign cand_hit[gi] = bus.req_valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) begin
        pick     = cand_idx[i];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_id_d  = grant_id_q;
    tx_data_d   = tx_data_q;
    gap_cnt_d   = gap_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    req_ready_c = 4'b0000;
    tx_start_c  = 1'b0;
    timeout_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          req_ready_c[pick] = 1'b1;
          tx_data_d         = bus.req_data[{pick, 3'b000} +: 8];
          grant_id_d        = pick;
          last_d            = pick;
          state_d           = START;
        end
      end
      START: begin
        tx_start_c = 1'b1;
        ack_cnt_d  = 16'd0;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          // The byte is dropped; the gap still applies so the line settles.
          timeout_c = 1'b1;
          gap_cnt_d = 32'd0;
          state_d   = NO_GAP ? IDLE : GAP;
        end else begin
          ack_cnt_d = ack_cnt_q + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          gap_cnt_d = 32'd0;
          state_d   = NO_GAP ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    sched_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 2'd3;
      grant_id_q   <= 2'd0;
      tx_data_q    <= 8'd0;
      gap_cnt_q    <= 32'd0;
      ack_cnt_q    <= 16'd0;
      sched_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      gap_cnt_q    <= gap_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      sched_busy_q <= sched_busy_d;
    end
  end

  // The state register already falls to IDLE during reset, but the grant path is
  // combinational from req_valid, so it is held off explicitly while rst_n is low.
  assign bus.req_ready   = rst_n ? req_ready_c : 4'b0000;
  assign bus.tx_start    = tx_start_c;
  assign bus.timeout_err = timeout_c;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.sched_busy  = sched_busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: one DUT with a 4-cycle gap, one with no gap,
// each driven by a small serializer model that raises tx_busy the cycle after tx_start.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  `define CHK(TAG, OBS, EXP) \
    begin \
      checks++; \
      assert ((OBS) === (EXP)) else begin \
        failures++; \
        $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
      end \
    end

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_sched_if ifa ();
  uart_tx_sched_if ifb ();

  uart_tx_sched #(.GAP_CYCLES(4), .ACK_TIMEOUT(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  uart_tx_sched #(.GAP_CYCLES(0), .ACK_TIMEOUT(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer models: tx_busy rises the cycle after tx_start and stays high for len cycles.
  bit ser_a_en  = 1'b1;
  int ser_a_len = 10;
  int ser_a_left = 0;
  bit ser_a_prev = 1'b0;
  int ser_b_left = 0;
  bit ser_b_prev = 1'b0;

  initial begin
    ifa.tx_busy = 1'b0;
    ifb.tx_busy = 1'b0;
  end

  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      ser_a_left = 0;
      ser_a_prev = 1'b0;
    end else begin
      if (ser_a_prev) ser_a_left = ser_a_len;
      else if (ser_a_left > 0) ser_a_left--;
      ser_a_prev = ifa.tx_start && ser_a_en;
    end
    ifa.tx_busy = (ser_a_left != 0);
  end

  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      ser_b_left = 0;
      ser_b_prev = 1'b0;
    end else begin
      if (ser_b_prev) ser_b_left = 3;
      else if (ser_b_left > 0) ser_b_left--;
      ser_b_prev = ifb.tx_start;
    end
    ifb.tx_busy = (ser_b_left != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for any req_ready bit on DUT a (sel=0) or b (sel=1).
  task automatic wait_grant(input bit sel, output logic [3:0] rdy, output int waited);
    waited = 0;
    #1;
    rdy = sel ? ifb.req_ready : ifa.req_ready;
    while (rdy == 4'b0000 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
      rdy = sel ? ifb.req_ready : ifa.req_ready;
    end
    checks++;
    assert (rdy !== 4'b0000) else begin
      failures++;
      $error("FAIL grant_wait observed=%0h expected=nonzero after %0d cycles", rdy, waited);
    end
  endtask

  int         exp_order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] rdy;
  int         w;
  int         n;

  initial begin
    rst_n = 1'b0;
    ifa.req_valid = 4'b0000;
    ifa.req_data  = 32'h44332211;
    ifb.req_valid = 4'b0000;
    ifb.req_data  = 32'hB3B2B1B0;

    // Reset state
    repeat (2) @(negedge clk);
    `CHK("rst_req_ready", ifa.req_ready, 4'b0000)
    `CHK("rst_tx_start", ifa.tx_start, 1'b0)
    `CHK("rst_tx_data", ifa.tx_data, 8'h00)
    `CHK("rst_grant_id", ifa.grant_id, 2'd0)
    `CHK("rst_sched_busy", ifa.sched_busy, 1'b0)
    `CHK("rst_timeout_err", ifa.timeout_err, 1'b0)
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 2, 10-cycle frame, 4-cycle gap
    ifa.req_data  = 32'h440F2211;
    ifa.req_valid = 4'b0100;
    #1;
    `CHK("t1_req_ready", ifa.req_ready, 4'b0100)
    @(negedge clk);
    `CHK("t1_tx_start", ifa.tx_start, 1'b1)
    `CHK("t1_tx_data", ifa.tx_data, 8'h0F)
    `CHK("t1_grant_id", ifa.grant_id, 2'd2)
    `CHK("t1_sched_busy", ifa.sched_busy, 1'b1)
    `CHK("t1_ready_gone", ifa.req_ready, 4'b0000)
    ifa.req_valid = 4'b0000;
    @(negedge clk);
    `CHK("t1_start_pulse", ifa.tx_start, 1'b0)
    n = 1;
    while (ifa.sched_busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    `CHK("t1_start_to_idle", n, 16)
    `CHK("t1_tx_data_held", ifa.tx_data, 8'h0F)

    // Fresh pointer, all four valid: strict rotation 0,1,2,3,0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ifa.req_data  = 32'hA3A2A1A0;
    ifa.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(1'b0, rdy, w);
      `CHK("t2_req_ready", rdy, 4'(1 << exp_order[i]))
      @(negedge clk);
      `CHK("t2_grant_id", ifa.grant_id, 2'(exp_order[i]))
      `CHK("t2_tx_data", ifa.tx_data, 8'(8'hA0 + exp_order[i]))
    end

    // Grant to 1, then only 1 and 3 remain: expect 3 then 1
    wait_grant(1'b0, rdy, w);
    `CHK("t3_first", rdy, 4'b0010)
    @(negedge clk);
    ifa.req_valid = 4'b1010;
    wait_grant(1'b0, rdy, w);
    `CHK("t3_second", rdy, 4'b1000)
    @(negedge clk);
    `CHK("t3_second_data", ifa.tx_data, 8'hA3)
    wait_grant(1'b0, rdy, w);
    `CHK("t3_third", rdy, 4'b0010)
    @(negedge clk);
    `CHK("t3_third_data", ifa.tx_data, 8'hA1)
    ifa.req_valid = 4'b0000;
    ser_a_en = 1'b0;

    // Serializer never acknowledges: timeout 16 cycles after tx_start
    ifa.req_valid = 4'b0101;
    wait_grant(1'b0, rdy, w);
    `CHK("t4_grant", rdy, 4'b0100)
    @(negedge clk);
    `CHK("t4_tx_start", ifa.tx_start, 1'b1)
    ifa.req_valid = 4'b0001;
    n = 0;
    while (ifa.timeout_err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    `CHK("t4_timeout_delay", n, 16)
    @(negedge clk);
    `CHK("t4_timeout_pulse", ifa.timeout_err, 1'b0)
    `CHK("t4_in_gap", ifa.sched_busy, 1'b1)
    wait_grant(1'b0, rdy, w);
    `CHK("t4_next_grant", rdy, 4'b0001)
    `CHK("t4_gap_len", w, 4)
    ser_a_en = 1'b1;
    @(negedge clk);
    ifa.req_valid = 4'b0000;

    // Reset while WAIT_DONE with all requesters valid
    repeat (3) @(negedge clk);
    `CHK("t5_busy_before", ifa.sched_busy, 1'b1)
    ifa.req_valid = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    `CHK("t5_tx_start", ifa.tx_start, 1'b0)
    `CHK("t5_req_ready", ifa.req_ready, 4'b0000)
    `CHK("t5_sched_busy", ifa.sched_busy, 1'b0)
    `CHK("t5_tx_data", ifa.tx_data, 8'h00)
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_grant(1'b0, rdy, w);
    `CHK("t5_first_grant", rdy, 4'b0001)
    `CHK("t5_grant_wait", w, 0)
    @(negedge clk);
    ifa.req_valid = 4'b0000;

    // No gap: next grant the cycle after tx_busy is sampled low
    ifb.req_valid = 4'b1111;
    wait_grant(1'b1, rdy, w);
    `CHK("t6_first", rdy, 4'b0001)
    @(negedge clk);
    `CHK("t6_tx_start", ifb.tx_start, 1'b1)
    `CHK("t6_tx_data", ifb.tx_data, 8'hB0)
    wait_grant(1'b1, rdy, w);
    `CHK("t6_second", rdy, 4'b0010)
    `CHK("t6_back_to_back", w, 5)
    @(negedge clk);
    `CHK("t6_second_data", ifb.tx_data, 8'hB1)
    ifb.req_valid = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
